exec_commit: RTL and testbench

Commit stage directly downstream of the DCPU-16 ALU. It consumes the ALU result, EX output and comparison flags for each basic instruction, owns the architectural EX register and feeds it back to the ALU `EXin`, and evaluates IFx conditions, including the skip-chaining state machine. It also drives a one-entry registered writeback buffer towards the register file and memory write path.

---
 rtl/dcpu_pkg.sv | 60 ++++++
 rtl/if_cond_eval.sv | 29 ++
 rtl/exec_commit.sv | 115 +++++++++++
 tb/tb_exec_commit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dcpu_pkg.sv
// rtl/dcpu_pkg.sv - DCPU-16 basic opcodes, skip states and opcode class helpers
package dcpu_pkg;

    typedef enum logic [4:0] {
        OP_SPECIAL = 5'h00,
        OP_SET     = 5'h01,
        OP_ADD     = 5'h02,
        OP_SUB     = 5'h03,
        OP_MUL     = 5'h04,
        OP_MLI     = 5'h05,
        OP_DIV     = 5'h06,
        OP_DVI     = 5'h07,
        OP_MOD     = 5'h08,
        OP_MDI     = 5'h09,
        OP_AND     = 5'h0a,
        OP_BOR     = 5'h0b,
        OP_XOR     = 5'h0c,
        OP_SHR     = 5'h0d,
        OP_ASR     = 5'h0e,
        OP_SHL     = 5'h0f,
        OP_IFB     = 5'h10,
        OP_IFC     = 5'h11,
        OP_IFE     = 5'h12,
        OP_IFN     = 5'h13,
        OP_IFG     = 5'h14,
        OP_IFA     = 5'h15,
        OP_IFL     = 5'h16,
        OP_IFU     = 5'h17,
        OP_RSV18   = 5'h18,
        OP_RSV19   = 5'h19,
        OP_ADX     = 5'h1a,
        OP_SBX     = 5'h1b,
        OP_RSV1C   = 5'h1c,
        OP_RSV1D   = 5'h1d,
        OP_STI     = 5'h1e,
        OP_STD     = 5'h1f
    } opcode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_SKIP = 1'b1
    } skip_state_e;

    // IF opcodes occupy exactly 0x10-0x17
    function automatic logic is_if(input logic [4:0] op);
        return (op[4:3] == 2'b10);
    endfunction

    function automatic logic writes_ex(input logic [4:0] op);
        logic r;
        r = 1'b0;
        case (opcode_e'(op))
            OP_ADD, OP_SUB, OP_MUL, OP_MLI, OP_DIV, OP_DVI,
            OP_SHR, OP_ASR, OP_SHL, OP_ADX, OP_SBX: r = 1'b1;
            default:                                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/if_cond_eval.sv
// rtl/if_cond_eval.sv - combinational IFx pass/fail evaluation from ALU flags
module if_cond_eval
    import dcpu_pkg::*;
(
    input  logic [4:0] op,
    input  logic       cl,
    input  logic       eq,
    input  logic       lt,
    input  logic       un,
    output logic       pass
);

    // Non-IF opcodes report pass so callers need not gate on is_if
    always_comb begin
        pass = 1'b1;
        case (opcode_e'(op))
            OP_IFB:  pass = !cl;
            OP_IFC:  pass = cl;
            OP_IFE:  pass = eq;
            OP_IFN:  pass = !eq;
            OP_IFG:  pass = !eq && !lt;
            OP_IFA:  pass = !eq && !un;
            OP_IFL:  pass = lt;
            OP_IFU:  pass = un;
            default: pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/exec_commit.sv
// rtl/exec_commit.sv - commit stage: EX register, IF skip chaining, writeback buffer
module exec_commit
    import dcpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [15:0] in_q,
    input  logic [15:0] in_exout,
    input  logic        in_cl,
    input  logic        in_eq,
    input  logic        in_lt,
    input  logic        in_un,
    input  logic        in_dest_we,
    input  logic        in_dest_is_ex,
    output logic [15:0] ex_value,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [15:0] wb_data,
    output logic        skip_active,
    output logic        retire,
    output logic        retire_skipped
);

    skip_state_e state;
    skip_state_e state_next;

    logic accept;
    logic op_is_if;
    logic op_writes_ex;
    logic cond_pass;
    logic run_accept;
    logic skip_accept;
    logic wb_load;
    logic ex_explicit;

    if_cond_eval u_if_cond_eval (
        .op   (in_op),
        .cl   (in_cl),
        .eq   (in_eq),
        .lt   (in_lt),
        .un   (in_un),
        .pass (cond_pass)
    );

    // Ready ignores the opcode so instructions never overtake a stalled write
    assign in_ready     = !wb_valid || wb_ready;
    assign accept       = in_valid && in_ready;
    assign op_is_if     = is_if(in_op);
    assign op_writes_ex = writes_ex(in_op);
    assign run_accept   = accept && (state == ST_RUN);
    assign skip_accept  = accept && (state == ST_SKIP);
    assign ex_explicit  = in_dest_is_ex && in_dest_we && !op_is_if;
    assign wb_load      = run_accept && !op_is_if && in_dest_we && !in_dest_is_ex;
    assign skip_active  = (state == ST_SKIP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // A discarded IF keeps skipping so a whole IF chain plus its target is dropped
    always_comb begin
        state_next = state;
        if (accept) begin
            case (state)
                ST_RUN:  if (op_is_if && !cond_pass) state_next = ST_SKIP;
                ST_SKIP: if (!op_is_if)              state_next = ST_RUN;
                default:                             state_next = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_value <= 16'h0000;
        end else if (run_accept) begin
            if (ex_explicit) begin
                ex_value <= in_q;
            end else if (op_writes_ex) begin
                ex_value <= in_exout;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_data  <= 16'h0000;
        end else begin
            if (wb_load) begin
                wb_valid <= 1'b1;
                wb_data  <= in_q;
            end else if (wb_ready) begin
                wb_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire         <= 1'b0;
            retire_skipped <= 1'b0;
        end else begin
            retire         <= run_accept;
            retire_skipped <= skip_accept;
        end
    end

endmodule

// File: tb/tb_exec_commit.sv
// tb/tb_exec_commit.sv - directed self-checking bench for exec_commit
module tb_exec_commit;
    import dcpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [15:0] in_q;
    logic [15:0] in_exout;
    logic        in_cl, in_eq, in_lt, in_un;
    logic        in_dest_we;
    logic        in_dest_is_ex;
    logic [15:0] ex_value;
    logic        wb_valid;
    logic        wb_ready;
    logic [15:0] wb_data;
    logic        skip_active;
    logic        retire;
    logic        retire_skipped;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exec_commit dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_op          (in_op),
        .in_q           (in_q),
        .in_exout       (in_exout),
        .in_cl          (in_cl),
        .in_eq          (in_eq),
        .in_lt          (in_lt),
        .in_un          (in_un),
        .in_dest_we     (in_dest_we),
        .in_dest_is_ex  (in_dest_is_ex),
        .ex_value       (ex_value),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_data        (wb_data),
        .skip_active    (skip_active),
        .retire         (retire),
        .retire_skipped (retire_skipped)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%04h exp=0x%04h", tag, got, exp);
        end
    endtask

    // f = {cl, eq, lt, un}; called #1 after an edge, returns #1 after the accept edge
    task automatic send(input logic [4:0] op, input logic [15:0] q, input logic [15:0] exo,
                        input logic [3:0] f, input logic we, input logic isex);
        in_op         = op;
        in_q          = q;
        in_exout      = exo;
        {in_cl, in_eq, in_lt, in_un} = f;
        in_dest_we    = we;
        in_dest_is_ex = isex;
        in_valid      = 1'b1;
        @(posedge clk);
        #1;
        in_valid      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_op = 5'h00;
        in_q = 16'h0;
        in_exout = 16'h0;
        {in_cl, in_eq, in_lt, in_un} = 4'b0000;
        in_dest_we = 1'b0;
        in_dest_is_ex = 1'b0;
        wb_ready = 1'b1;
        tick();
        tick();
        check("rst_ex", ex_value, 16'h0000);
        check("rst_wb_valid", {15'b0, wb_valid}, 16'h0);
        check("rst_wb_data", wb_data, 16'h0000);
        check("rst_skip", {15'b0, skip_active}, 16'h0);
        check("rst_retire", {15'b0, retire}, 16'h0);
        check("rst_retire_skipped", {15'b0, retire_skipped}, 16'h0);
        check("rst_in_ready", {15'b0, in_ready}, 16'h1);
        reset = 1'b0;
        tick();

        send(OP_ADD, 16'h0000, 16'h0001, 4'b0000, 1'b1, 1'b0);
        check("add_wb_valid", {15'b0, wb_valid}, 16'h1);
        check("add_wb_data", wb_data, 16'h0000);
        check("add_ex", ex_value, 16'h0001);
        check("add_retire", {15'b0, retire}, 16'h1);

        send(OP_MOD, 16'h9999, 16'h5555, 4'b0000, 1'b1, 1'b0);
        check("mod_ex_hold", ex_value, 16'h0001);
        check("mod_wb_data", wb_data, 16'h9999);

        send(OP_ADD, 16'h1234, 16'h0001, 4'b0000, 1'b1, 1'b1);
        check("add_ex_dest", ex_value, 16'h1234);
        check("add_ex_dest_no_wb", {15'b0, wb_valid}, 16'h0);

        send(OP_IFE, 16'h0000, 16'h0000, 4'b0000, 1'b0, 1'b0);
        check("ife_fail_skip", {15'b0, skip_active}, 16'h1);
        check("ife_no_wb", {15'b0, wb_valid}, 16'h0);
        send(OP_SET, 16'h00AA, 16'h0000, 4'b0000, 1'b1, 1'b0);
        check("set_skipped_pulse", {15'b0, retire_skipped}, 16'h1);
        check("set_skipped_no_wb", {15'b0, wb_valid}, 16'h0);
        check("set_skipped_exit", {15'b0, skip_active}, 16'h0);
        send(OP_SET, 16'h00BB, 16'h0000, 4'b0000, 1'b1, 1'b0);
        check("set_bb_valid", {15'b0, wb_valid}, 16'h1);
        check("set_bb_data", wb_data, 16'h00BB);

        send(OP_IFN, 16'h0000, 16'h0000, 4'b0100, 1'b0, 1'b0);
        check("ifn_fail_skip", {15'b0, skip_active}, 16'h1);
        send(OP_IFG, 16'h0000, 16'h0000, 4'b0000, 1'b0, 1'b0);
        check("ifg_chain_skip", {15'b0, skip_active}, 16'h1);
        check("ifg_chain_pulse", {15'b0, retire_skipped}, 16'h1);
        send(OP_ADD, 16'h0003, 16'h0002, 4'b0000, 1'b1, 1'b0);
        check("chain_add_exit", {15'b0, skip_active}, 16'h0);
        check("chain_add_ex", ex_value, 16'h1234);
        check("chain_add_no_wb", {15'b0, wb_valid}, 16'h0);
        send(OP_SET, 16'h0007, 16'h0000, 4'b0000, 1'b1, 1'b0);
        check("chain_set_valid", {15'b0, wb_valid}, 16'h1);
        check("chain_set_data", wb_data, 16'h0007);

        send(OP_IFG, 16'h0000, 16'h0000, 4'b0000, 1'b0, 1'b0);
        check("ifg_pass", {15'b0, skip_active}, 16'h0);
        send(OP_IFA, 16'h0000, 16'h0000, 4'b0001, 1'b0, 1'b0);
        check("ifa_un_fail", {15'b0, skip_active}, 16'h1);
        send(OP_SHL, 16'h0000, 16'h0BAD, 4'b0000, 1'b1, 1'b0);
        check("shl_skipped_ex", ex_value, 16'h1234);
        send(OP_IFC, 16'h0000, 16'h0000, 4'b1000, 1'b0, 1'b0);
        check("ifc_pass", {15'b0, skip_active}, 16'h0);
        send(OP_IFL, 16'h0000, 16'h0000, 4'b0000, 1'b0, 1'b0);
        check("ifl_fail", {15'b0, skip_active}, 16'h1);
        send(OP_SET, 16'h0000, 16'h0000, 4'b0000, 1'b1, 1'b0);
        check("ifl_exit", {15'b0, skip_active}, 16'h0);

        // Backpressure: the stalled write must stay put and block new accepts
        wb_ready = 1'b0;
        send(OP_SET, 16'h0033, 16'h0000, 4'b0000, 1'b1, 1'b0);
        check("bp_valid", {15'b0, wb_valid}, 16'h1);
        in_q = 16'h0044;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", {15'b0, in_ready}, 16'h0);
            tick();
            check("bp_data_stable", wb_data, 16'h0033);
        end
        in_q = 16'h0042;
        wb_ready = 1'b1;
        #1;
        check("bp_release_ready", {15'b0, in_ready}, 16'h1);
        tick();
        in_valid = 1'b0;
        check("bp_replace_valid", {15'b0, wb_valid}, 16'h1);
        check("bp_replace_data", wb_data, 16'h0042);
        tick();
        check("bp_drain", {15'b0, wb_valid}, 16'h0);

        send(OP_SBX, 16'h0000, 16'hFFFF, 4'b0000, 1'b0, 1'b0);
        check("sbx_ex", ex_value, 16'hFFFF);
        send(OP_IFB, 16'h0000, 16'h0000, 4'b1000, 1'b0, 1'b0);
        check("ifb_fail", {15'b0, skip_active}, 16'h1);
        #2 reset = 1'b1;
        #1;
        check("arst_skip", {15'b0, skip_active}, 16'h0);
        check("arst_ex", ex_value, 16'h0000);
        check("arst_retire", {15'b0, retire}, 16'h0);
        #2 reset = 1'b0;
        tick();

        wb_ready = 1'b0;
        send(OP_SET, 16'h0066, 16'h0000, 4'b0000, 1'b1, 1'b0);
        check("pend_valid", {15'b0, wb_valid}, 16'h1);
        #2 reset = 1'b1;
        #1;
        check("arst_wb_valid", {15'b0, wb_valid}, 16'h0);
        check("arst_wb_data", wb_data, 16'h0000);
        check("arst_in_ready", {15'b0, in_ready}, 16'h1);
        #2 reset = 1'b0;
        wb_ready = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
